// File: rtl/modport_reg_file_pkg.sv
// Shared constants and types for the integer register file.
// Index and data widths are derived here so every file agrees on them.
package modport_reg_file_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);

  function automatic logic is_zero_reg(input reg_addr_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/modport_reg_file_if.sv
// Write-back and operand-read bundle between the core datapath and the register file.
// The datapath side is the master; the register file is the slave.
interface modport_reg_file_if;
  import modport_reg_file_pkg::*;

  logic      wr_en;
  reg_addr_t wr_reg;
  word_t     wr_data;
  reg_addr_t rd_reg_1;
  reg_addr_t rd_reg_2;
  word_t     rd_data_1;
  word_t     rd_data_2;

  modport master (
    output wr_en,
    output wr_reg,
    output wr_data,
    output rd_reg_1,
    output rd_reg_2,
    input  rd_data_1,
    input  rd_data_2
  );

  modport slave (
    input  wr_en,
    input  wr_reg,
    input  wr_data,
    input  rd_reg_1,
    input  rd_reg_2,
    output rd_data_1,
    output rd_data_2
  );

endinterface

// File: rtl/modport_reg_file_read_port.sv
// Combinational read mux over the register array; index x0 always returns zero.
// Zero latency: output follows the index and array contents within the same cycle.
module modport_reg_file_read_port
  import modport_reg_file_pkg::*;
(
  input  word_t     i_regs [NUM_REGS],
  input  reg_addr_t i_idx,
  output word_t     o_data
);

  always_comb begin
    o_data = '0;
    if (!is_zero_reg(i_idx)) begin
      o_data = i_regs[i_idx];
    end
  end

endmodule

// File: rtl/modport_reg_file.sv
// RISC-V integer register file: two combinational read ports, one synchronous write port.
// Writes land on the rising edge and are visible on reads right after; there is no bypass.
module modport_reg_file
  import modport_reg_file_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  modport_reg_file_if.slave  bus
);

  word_t                 r_regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]   w_wr_onehot;
  word_t                 w_regs [NUM_REGS];

  // One-hot decode; x0 has no enable so writes to it simply vanish.
  always_comb begin
    w_wr_onehot = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_wr_onehot[i] = bus.wr_en && (bus.wr_reg == reg_addr_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wr_onehot[i]) begin
          r_regs[i] <= bus.wr_data;
        end
      end
    end
  end

  always_comb begin
    w_regs[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_regs[i] = r_regs[i];
    end
  end

  modport_reg_file_read_port u_rd_port_1 (
    .i_regs (w_regs),
    .i_idx  (bus.rd_reg_1),
    .o_data (bus.rd_data_1)
  );

  modport_reg_file_read_port u_rd_port_2 (
    .i_regs (w_regs),
    .i_idx  (bus.rd_reg_2),
    .o_data (bus.rd_data_2)
  );

endmodule

// File: tb/tb_modport_reg_file.sv
// Directed bench for modport_reg_file: reset, write/read, x0, read-during-write, sweep.
module tb_modport_reg_file;
  import modport_reg_file_pkg::*;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  modport_reg_file_if bus ();

  modport_reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input reg_addr_t idx, input word_t data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_reg  = idx;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_both(input reg_addr_t a, input reg_addr_t b);
    bus.rd_reg_1 = a;
    bus.rd_reg_2 = b;
    #1;
  endtask

  initial begin
    word_t exp_a;
    word_t exp_b;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_reg   = '0;
    bus.wr_data  = '0;
    bus.rd_reg_1 = reg_addr_t'(1);
    bus.rd_reg_2 = reg_addr_t'(31);

    #12;
    check("reset_rd1", bus.rd_data_1, 32'h0000_0000);
    check("reset_rd2", bus.rd_data_2, 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      read_both(reg_addr_t'(i), reg_addr_t'(i));
      check("post_reset_zero", bus.rd_data_1, 32'h0000_0000);
    end

    // Basic write then read on both ports.
    write_reg(reg_addr_t'(5), 32'hDEAD_BEEF);
    read_both(reg_addr_t'(5), reg_addr_t'(5));
    check("x5_rd1", bus.rd_data_1, 32'hDEAD_BEEF);
    check("x5_rd2", bus.rd_data_2, 32'hDEAD_BEEF);

    // x0 stays zero after an attempted write.
    write_reg(reg_addr_t'(0), 32'hFFFF_FFFF);
    read_both(reg_addr_t'(0), reg_addr_t'(0));
    for (int c = 0; c < 3; c++) begin
      check("x0_rd1", bus.rd_data_1, 32'h0000_0000);
      check("x0_rd2", bus.rd_data_2, 32'h0000_0000);
      @(negedge clk);
    end

    // wr_en low leaves the register alone.
    write_reg(reg_addr_t'(7), 32'hA5A5_A5A5);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.wr_reg  = reg_addr_t'(7);
    bus.wr_data = 32'h1234_5678;
    @(posedge clk);
    #1;
    read_both(reg_addr_t'(7), reg_addr_t'(5));
    check("x7_wr_disabled", bus.rd_data_1, 32'hA5A5_A5A5);
    check("x5_untouched", bus.rd_data_2, 32'hDEAD_BEEF);

    // Read during write: old value before the edge, new value after.
    write_reg(reg_addr_t'(3), 32'h1111_1111);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_reg   = reg_addr_t'(3);
    bus.wr_data  = 32'h2222_2222;
    bus.rd_reg_1 = reg_addr_t'(3);
    #1;
    check("rdw_before_edge", bus.rd_data_1, 32'h1111_1111);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    check("rdw_after_edge", bus.rd_data_1, 32'h2222_2222);

    // Full sweep of x1..x31 followed by paired reads.
    for (int i = 1; i < NUM_REGS; i++) begin
      write_reg(reg_addr_t'(i), 32'h0101_0101 * word_t'(i));
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      read_both(reg_addr_t'(i), reg_addr_t'(31 - i));
      exp_a = 32'h0101_0101 * word_t'(i);
      exp_b = 32'h0101_0101 * word_t'(31 - i);
      check("sweep_rd1", bus.rd_data_1, exp_a);
      check("sweep_rd2", bus.rd_data_2, exp_b);
    end
    read_both(reg_addr_t'(31), reg_addr_t'(0));
    check("sweep_x31", bus.rd_data_1, 32'h1F1F_1F1F);
    check("sweep_x0", bus.rd_data_2, 32'h0000_0000);

    // Mid-cycle reset with a write pending: reset clears and wins.
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_reg   = reg_addr_t'(31);
    bus.wr_data  = 32'hCAFE_F00D;
    bus.rd_reg_1 = reg_addr_t'(31);
    bus.rd_reg_2 = reg_addr_t'(17);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_rd1", bus.rd_data_1, 32'h0000_0000);
    check("midreset_rd2", bus.rd_data_2, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("reset_blocks_write", bus.rd_data_1, 32'h0000_0000);
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < NUM_REGS; i++) begin
      read_both(reg_addr_t'(i), reg_addr_t'(NUM_REGS - i));
      check("rerelease_rd1", bus.rd_data_1, 32'h0000_0000);
      check("rerelease_rd2", bus.rd_data_2, 32'h0000_0000);
    end

    // Writes resume normally after the second reset.
    write_reg(reg_addr_t'(9), 32'h0BAD_CAFE);
    read_both(reg_addr_t'(9), reg_addr_t'(9));
    check("post_reset_write", bus.rd_data_2, 32'h0BAD_CAFE);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/modport_reg_file.md
Name: modport_reg_file

Overview:
- RISC-V integer register file for the single-cycle/pipelined core datapath: 32 registers of 32 bits.
- Two asynchronous (combinational) read ports feed the ALU operand muxes.
- One synchronous write port is driven from writeback.
- Register x0 is hardwired to zero.

Parameters:
- XLEN, 32, data width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers. Must be a power of two.
- ADDR_W, $clog2(NUM_REGS) = 5, register index width. Derived; not overridden.

Ports:
- clk  input  1  system clock. All state updates occur on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  write enable, sampled at posedge clk.
- wr_reg  input  ADDR_W  destination register index.
- wr_data  input  XLEN  data to write.
- rd_reg_1  input  ADDR_W  read port 1 register index.
- rd_reg_2  input  ADDR_W  read port 2 register index.
- rd_data_1  output  XLEN  contents of register rd_reg_1.
- rd_data_2  output  XLEN  contents of register rd_reg_2.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset:
  - rst_n low immediately clears all NUM_REGS registers to 0, independent of clk.
  - While rst_n is low, writes are ignored and both rd_data outputs read 0.
  - Release of rst_n is synchronised by the integrator; the block places no requirement on it.
- Write:
  - At posedge clk with rst_n high and wr_en=1, regs[wr_reg] <= wr_data.
  - Latency is 1 cycle: the new value is visible on the read ports after the edge.
  - wr_en=0 leaves all registers unchanged.
- x0:
  - Writes to index 0 are discarded.
  - rd_data_n is 0 whenever rd_reg_n == 0. Storage for x0 may be omitted.
- Read:
  - Purely combinational: rd_data_n = regs[rd_reg_n].
  - No clock is involved; outputs settle within the same cycle the address changes.
- Same-cycle read/write of the same index:
  - No internal bypass. The read returns the old value until the write edge, then the new value.
  - Forwarding is the pipeline's responsibility.
- Both read ports may address the same register, including x0. Both return identical data.
- Reset asserted mid-cycle with wr_en high: reset wins; the register ends at 0.
- No X propagation: every register has a defined value after the first reset.

Decomposition:
- Shared package riscv_pkg holds:
  - constants XLEN=32, NUM_REGS=32, REG_ADDR_W=5, REG_ZERO=5'd0;
  - typedefs word_t (logic [XLEN-1:0]) and reg_addr_t (logic [REG_ADDR_W-1:0]).
- One natural sub-module, reg_read_port: a combinational mux from the register array plus an index, with the x0 forced-zero logic. It is instantiated twice.
- The write decode (one-hot enable per register, excluding x0) stays in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-cycle after registers hold nonzero data -> all reads return 32'h0000_0000 immediately. After release, reading x1..x31 returns 0.
- Basic write/read: wr_en=1, wr_reg=5, wr_data=32'hDEAD_BEEF; next cycle rd_reg_1=5, rd_reg_2=5 -> both rd_data = 32'hDEAD_BEEF.
- x0 immutability: wr_en=1, wr_reg=0, wr_data=32'hFFFF_FFFF -> rd_reg_1=0 yields 32'h0 on every subsequent cycle.
- Write disabled: wr_en=0, wr_reg=7, wr_data=32'h1234_5678 after x7 was loaded with 32'hA5A5_A5A5 -> x7 still reads 32'hA5A5_A5A5.
- Same-cycle read-during-write: x3=32'h1111_1111; drive wr_en=1, wr_reg=3, wr_data=32'h2222_2222 with rd_reg_1=3 -> rd_data_1=32'h1111_1111 before the edge, 32'h2222_2222 after it.
- Full sweep: write x(i)=i*32'h0101_0101 for i=1..31, then read pairs (i, 31-i) on both ports -> each port returns the expected value; x31 returns 32'h1F1F_1F1F and x0 returns 0.
